// File: rtl/fifo_stream_drain.sv
// Drains a FIFO through a 2-entry skid buffer onto a valid/ready stream, with a beat counter.
// Optional packet last-flag generator: define FIFO_STREAM_DRAIN_LAST_GEN_EN.
module fifo_stream_drain #(
   parameter int SIZE       = 16,
   parameter int CNT_WIDTH  = 16,
   parameter int PACKET_LEN = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 fifo_empty,
   input  logic [SIZE-1:0]      fifo_data,
   output logic                 fifo_read_update,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SIZE-1:0]      out_data,
   output logic                 out_last,
   output logic [CNT_WIDTH-1:0] beat_count,
   output logic                 idle
);

   // Stream handshake: a word transfers on every rising edge where out_valid and out_ready
   // are both 1; out_data is held stable while out_valid=1 and out_ready=0.
   logic [1:0]      occupancy, occupancy_next;
   logic [SIZE-1:0] head, tail, head_next, tail_next;
   logic            fire;

   // The pop decision uses registered occupancy only, so out_ready never reaches the FIFO.
   assign fifo_read_update = enable & ~fifo_empty & (occupancy != 2'd2) & ~reset;
   assign out_valid        = (occupancy != 2'd0);
   assign out_data         = head;
   assign fire             = out_valid & out_ready;
   assign idle             = (occupancy == 2'd0) & fifo_empty;

   always_comb begin
      occupancy_next = occupancy;
      head_next      = head;
      tail_next      = tail;
      if (fire) begin
         head_next      = tail;
         tail_next      = '0;
         occupancy_next = occupancy - 2'd1;
      end
      // A popped word lands in the first free slot after any departure this cycle.
      if (fifo_read_update) begin
         if (occupancy_next == 2'd0) head_next = fifo_data;
         else                        tail_next = fifo_data;
         occupancy_next = occupancy_next + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occupancy  <= 2'd0;
         head       <= '0;
         tail       <= '0;
         beat_count <= '0;
      end else begin
         occupancy <= occupancy_next;
         head      <= head_next;
         tail      <= tail_next;
         if (fire) beat_count <= beat_count + CNT_WIDTH'(1);
      end
   end

`ifdef FIFO_STREAM_DRAIN_LAST_GEN_EN
   logic [CNT_WIDTH-1:0] beat_index;
   logic                 at_last;

   assign at_last  = (beat_index == CNT_WIDTH'(PACKET_LEN - 1));
   assign out_last = out_valid & at_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      beat_index <= '0;
      else if (fire)  beat_index <= at_last ? '0 : beat_index + CNT_WIDTH'(1);
   end
`else
   assign out_last = 1'b0;
`endif

   occupancy_in_range: assert property (@(posedge clk) disable iff (reset) occupancy != 2'd3);

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream consumer of the FIFO. Pops words through the FIFO's read_update/empty/data_out interface and presents them as a valid/ready stream to the next datapath stage.
- Holds a 2-entry output buffer, so out_ready never combinationally drives fifo_read_update.
- Sustains 1 word/cycle under continuous ready.
- Also keeps a running beat count for debug and flow monitoring.

Parameters:
SIZE, 16, data word width in bits; must match the feeding FIFO's SIZE.
CNT_WIDTH, 16, width of the transferred-beat counter.
PACKET_LEN, 8, beats per packet for the optional last-flag generator; legal range 1..2^CNT_WIDTH-1.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset of all state
enable  input  1  when 0, no new pops are issued; buffered words still drain
fifo_empty  input  1  FIFO empty flag
fifo_data  input  SIZE  FIFO head word (data_out); valid in the same cycle while fifo_empty=0
fifo_read_update  output  1  pop strobe to FIFO; FIFO advances its read pointer on the next rising edge
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  SIZE  oldest buffered word
out_last  output  1  last beat of a packet (only with the optional feature; tied 0 otherwise)
beat_count  output  CNT_WIDTH  number of completed out handshakes since reset, wraps modulo 2^CNT_WIDTH
idle  output  1  buffer empty and fifo_empty=1

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - occupancy=0, both buffer entries cleared to 0, beat_count=0, packet beat index=0.
  - out_valid=0, out_data=0, out_last=0, fifo_read_update=0.
  - idle=fifo_empty.
  - Asserting reset mid-transfer discards buffered words; words still in the FIFO are not touched.
- Buffer: 2 entries (head, tail) plus a 2-bit occupancy register (0..2). Occupancy 3 is unreachable and must assert in simulation.
- Pop rule (combinational, from registered state only): fifo_read_update = enable & ~fifo_empty & (occupancy != 2).
  - fifo_read_update never depends on out_ready.
- Capture: when fifo_read_update=1, fifo_data is written into the buffer at the same edge.
- Output:
  - out_valid = (occupancy != 0).
  - out_data = head entry, driven from a register; no combinational path from fifo_data.
- Handshake:
  - fire = out_valid & out_ready.
  - On fire, the head is removed and the tail shifts into the head.
  - out_data must remain stable while out_valid=1 and out_ready=0.
- Simultaneous pop and fire:
  - occupancy unchanged.
  - At occupancy 1, the new word goes to head.
  - At occupancy 2 no pop occurs, by rule.
- Latency: word at FIFO head with buffer empty → out_valid=1 the cycle after fifo_read_update.
- Throughput:
  - Steady state is occupancy 1 with fire+pop every cycle, i.e. 1 word/cycle.
  - A consumer stall fills the buffer to 2, then pops stop.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- beat_count increments by 1 on each fire and wraps from all-ones to 0.
- enable=0: pops stop the same cycle; fire and beat_count continue.

Optional Feature:
Macro FIFO_STREAM_DRAIN_LAST_GEN_EN.
- Defined:
  - A packet index counter (0..PACKET_LEN-1) increments on each fire and wraps to 0 after the fire where out_last=1.
  - out_last = out_valid & (index == PACKET_LEN-1).
  - PACKET_LEN=1 gives out_last=1 on every valid beat.
- Undefined: no index counter is built and out_last is constant 0.

Test Plan:
1. Reset mid-stream: preload FIFO with 5 words, pop 2, assert reset → occupancy 0, out_valid=0, beat_count=0. The FIFO still holds the undrained words.
2. Single word: FIFO holds 0x00A5 with buffer empty → fifo_read_update=1 for one cycle; next cycle out_valid=1, out_data=0x00A5; out_ready=1 → beat_count=1 and idle=1 afterwards.
3. Streaming: 16 words 0..15 with out_ready held 1 → outputs 0..15 in order on 16 consecutive cycles after the first-word latency; beat_count=16.
4. Backpressure: FIFO holds 10 words, out_ready=0 → exactly 2 pops, then fifo_read_update=0 and out_data stable at word 0. Release out_ready → remaining words appear in order with no loss.
5. Enable and wrap: enable=0 with a non-empty FIFO → no pops. Set CNT_WIDTH=4 and stream 17 beats → beat_count=1.
6. With FIFO_STREAM_DRAIN_LAST_GEN_EN, PACKET_LEN=4, 8 beats with random out_ready stalls → out_last=1 only on beats 4 and 8, held stable through stalls.
